dbus_arbiter: RTL and testbench

Two-master arbiter for the 32-bit req/gnt/rvalid data bus; it shares a single slave port, normally peripheral_block, between master 0 (processor_block data port) and master 1 (a second bus master such as a DMA or debug agent). Arbitration is round-robin. Grant ownership of every accepted transfer is recorded in an in-order FIFO so that each response is routed back to the master that issued it. The block adds zero cycles of latency on both the request and response paths.

---
 rtl/dbus_arbiter.sv | 143 ++++++++++++++
 tb/tb_dbus_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/dbus_arbiter.sv
// ---------------------------------------------------------------------------
// dbus_arbiter : two-master round-robin arbiter for the req/gnt/rvalid data bus
// Optional master-0 bus lock via DBUS_ARB_LOCK_EN.       Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dbus_arbiter #(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  m_req,
  output logic [1:0]  m_gnt,
  input  logic [1:0]  m_we,
  input  logic [7:0]  m_be,
  input  logic [63:0] m_addr,
  input  logic [63:0] m_wdata,
  output logic [1:0]  m_rvalid,
  output logic [31:0] m_rdata,
  output logic [1:0]  m_err,
`ifdef DBUS_ARB_LOCK_EN
  input  logic        m0_lock,
`endif
  output logic        s_req,
  output logic        s_we,
  output logic [3:0]  s_be,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  input  logic        s_gnt,
  input  logic        s_rvalid,
  input  logic [31:0] s_rdata,
  input  logic        s_err
);

  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW = $clog2(MAX_OUTSTANDING) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(MAX_OUTSTANDING);
  localparam logic [PW-1:0] LAST_PTR = PW'(MAX_OUTSTANDING - 1);

  logic [MAX_OUTSTANDING-1:0] owner_q;
  logic [PW-1:0]              wr_ptr;
  logic [PW-1:0]              rd_ptr;
  logic [CW-1:0]              count;
  logic                       hold_valid;
  logic                       hold_sel;
  logic                       last_win;

  logic       full;
  logic       empty;
  logic       lock_m1;
  logic [1:0] eligible;
  logic       sel;
  logic       sel_valid;
  logic       accept;
  logic       pop;
  logic       owner;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

`ifdef DBUS_ARB_LOCK_EN
  assign lock_m1 = m0_lock & ~last_win;
`else
  assign lock_m1 = 1'b0;
`endif

  assign eligible[0] = m_req[0] & ~full;
  assign eligible[1] = m_req[1] & ~full & ~lock_m1;

  // A held request bypasses the lock; a dropped held request falls through to
  // a fresh arbitration in the same cycle.
  always_comb begin
    sel       = 1'b0;
    sel_valid = 1'b0;
    if (hold_valid && m_req[hold_sel] && !full) begin
      sel       = hold_sel;
      sel_valid = 1'b1;
    end else if (eligible == 2'b11) begin
      sel       = ~last_win;
      sel_valid = 1'b1;
    end else if (eligible[1]) begin
      sel       = 1'b1;
      sel_valid = 1'b1;
    end else if (eligible[0]) begin
      sel       = 1'b0;
      sel_valid = 1'b1;
    end
  end

  assign s_req   = rst & sel_valid;
  assign s_we    = sel ? m_we[1]         : m_we[0];
  assign s_be    = sel ? m_be[7:4]       : m_be[3:0];
  assign s_addr  = sel ? m_addr[63:32]   : m_addr[31:0];
  assign s_wdata = sel ? m_wdata[63:32]  : m_wdata[31:0];

  assign accept = s_req & s_gnt;
  assign m_gnt  = accept ? (sel ? 2'b10 : 2'b01) : 2'b00;

  assign pop      = rst & s_rvalid & ~empty;
  assign owner    = owner_q[rd_ptr];
  assign m_rvalid = pop ? (owner ? 2'b10 : 2'b01) : 2'b00;
  assign m_err    = m_rvalid & {2{s_err}};
  assign m_rdata  = s_rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_q    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      hold_valid <= 1'b0;
      hold_sel   <= 1'b0;
      last_win   <= 1'b1;
    end else begin
      if (accept) begin
        owner_q[wr_ptr] <= sel;
        wr_ptr          <= ptr_next(wr_ptr);
        last_win        <= sel;
      end
      if (pop) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (s_req && !s_gnt) begin
        hold_valid <= 1'b1;
        hold_sel   <= sel;
      end else begin
        hold_valid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dbus_arbiter.sv
// Self-checking bench for dbus_arbiter: vector table plus hand-written corner
// sequences, with an in-order ownership scoreboard for responses.
`default_nettype none

module tb_dbus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  m_req;
  logic [1:0]  m_gnt;
  logic [1:0]  m_we;
  logic [7:0]  m_be;
  logic [63:0] m_addr;
  logic [63:0] m_wdata;
  logic [1:0]  m_rvalid;
  logic [31:0] m_rdata;
  logic [1:0]  m_err;
  logic        s_req;
  logic        s_we;
  logic [3:0]  s_be;
  logic [31:0] s_addr;
  logic [31:0] s_wdata;
  logic        s_gnt;
  logic        s_rvalid;
  logic [31:0] s_rdata;
  logic        s_err;
`ifdef DBUS_ARB_LOCK_EN
  logic        m0_lock = 1'b0;
`endif

  int tests  = 0;
  int errors = 0;
  int sb[$];

  logic [31:0] ADDR  [2] = '{32'h0000_1000, 32'h0000_2000};
  logic [31:0] WDATA [2] = '{32'hDEAD_BEEF, 32'h1234_5678};
  logic [3:0]  BE    [2] = '{4'hF, 4'h3};
  logic        WE    [2] = '{1'b1, 1'b0};

  typedef struct {
    logic [1:0] req;
    logic       gnt;
    logic       rv;
    logic       err;
    int         exp_m;
  } vec_t;

  vec_t vecs [10];

  always #5 clk = ~clk;

  dbus_arbiter #(.MAX_OUTSTANDING(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .m_req    (m_req),
    .m_gnt    (m_gnt),
    .m_we     (m_we),
    .m_be     (m_be),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_rvalid (m_rvalid),
    .m_rdata  (m_rdata),
    .m_err    (m_err),
`ifdef DBUS_ARB_LOCK_EN
    .m0_lock  (m0_lock),
`endif
    .s_req    (s_req),
    .s_we     (s_we),
    .s_be     (s_be),
    .s_addr   (s_addr),
    .s_wdata  (s_wdata),
    .s_gnt    (s_gnt),
    .s_rvalid (s_rvalid),
    .s_rdata  (s_rdata),
    .s_err    (s_err)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drive one cycle at the falling edge, compare combinational outputs 1ns later.
  task automatic step(input string nm, input logic [1:0] req, input logic gnt,
                      input logic rv, input logic er, input int exp_m);
    logic [1:0]  exp_gnt;
    logic [1:0]  exp_rv;
    logic [31:0] rd;
    int          own;
    rd       = $urandom;
    m_req    = req;
    s_gnt    = gnt;
    s_rvalid = rv;
    s_err    = er;
    s_rdata  = rd;
    #1;
    exp_gnt = (gnt && exp_m >= 0) ? ((exp_m == 1) ? 2'b10 : 2'b01) : 2'b00;
    check({nm, " s_req"}, 32'(s_req), 32'(exp_m >= 0));
    check({nm, " m_gnt"}, 32'(m_gnt), 32'(exp_gnt));
    if (exp_m >= 0) begin
      check({nm, " s_addr"},  s_addr,        ADDR[exp_m]);
      check({nm, " s_wdata"}, s_wdata,       WDATA[exp_m]);
      check({nm, " s_be"},    32'(s_be),     32'(BE[exp_m]));
      check({nm, " s_we"},    32'(s_we),     32'(WE[exp_m]));
    end
    exp_rv = 2'b00;
    if (rv && sb.size() > 0) begin
      own    = sb.pop_front();
      exp_rv = (own == 1) ? 2'b10 : 2'b01;
    end
    check({nm, " m_rvalid"}, 32'(m_rvalid), 32'(exp_rv));
    check({nm, " m_err"},    32'(m_err),    32'(er ? exp_rv : 2'b00));
    check({nm, " m_rdata"},  m_rdata,       rd);
    if (gnt && exp_m >= 0) sb.push_back(exp_m);
    @(negedge clk);
  endtask

  // Hold reset low with every input active; all handshake outputs must stay low.
  task automatic reset_check(input string nm);
    rst      = 1'b0;
    m_req    = 2'b11;
    s_gnt    = 1'b1;
    s_rvalid = 1'b1;
    s_err    = 1'b1;
    #1;
    check({nm, " m_gnt"},    32'(m_gnt),    32'h0);
    check({nm, " m_rvalid"}, 32'(m_rvalid), 32'h0);
    check({nm, " m_err"},    32'(m_err),    32'h0);
    check({nm, " s_req"},    32'(s_req),    32'h0);
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    rst      = 1'b1;
    m_req    = 2'b00;
    s_gnt    = 1'b0;
    s_rvalid = 1'b0;
    s_err    = 1'b0;
  endtask

  initial begin
    vecs[0] = '{2'b01, 1'b1, 1'b0, 1'b0,  0};
    vecs[1] = '{2'b00, 1'b0, 1'b1, 1'b0, -1};
    vecs[2] = '{2'b11, 1'b1, 1'b0, 1'b0,  1};
    vecs[3] = '{2'b11, 1'b1, 1'b1, 1'b0,  0};
    vecs[4] = '{2'b11, 1'b1, 1'b0, 1'b0,  1};
    vecs[5] = '{2'b11, 1'b1, 1'b0, 1'b0, -1};
    vecs[6] = '{2'b11, 1'b1, 1'b1, 1'b1, -1};
    vecs[7] = '{2'b11, 1'b1, 1'b1, 1'b0,  0};
    vecs[8] = '{2'b00, 1'b0, 1'b1, 1'b1, -1};
    vecs[9] = '{2'b00, 1'b0, 1'b1, 1'b0, -1};

    m_addr  = {ADDR[1], ADDR[0]};
    m_wdata = {WDATA[1], WDATA[0]};
    m_be    = {BE[1], BE[0]};
    m_we    = {WE[1], WE[0]};
    s_rdata = '0;
    @(negedge clk);
    reset_check("reset");

    // Stall with hold, then full FIFO, error response and hold release.
    for (int i = 0; i < 3; i++) step("stall", 2'b11, 1'b0, 1'b0, 1'b0, 0);
    step("stall_go",  2'b11, 1'b1, 1'b0, 1'b0, 0);
    step("after_hold", 2'b11, 1'b1, 1'b0, 1'b0, 1);
    step("full",      2'b11, 1'b1, 1'b0, 1'b0, -1);
    step("full_pop",  2'b11, 1'b1, 1'b1, 1'b1, -1);
    step("reassert",  2'b11, 1'b0, 1'b0, 1'b0, 0);
    step("hold_drop", 2'b10, 1'b0, 1'b1, 1'b0, 1);
    step("idle",      2'b00, 1'b0, 1'b0, 1'b0, -1);

    // Reset with two transfers outstanding; later response must be dropped.
    step("pre_rst_a", 2'b01, 1'b1, 1'b0, 1'b0, 0);
    step("pre_rst_b", 2'b10, 1'b1, 1'b0, 1'b0, 1);
    reset_check("mid_reset");
    step("post_rst",  2'b00, 1'b0, 1'b1, 1'b0, -1);

    for (int i = 0; i < 10; i++) begin
      step($sformatf("vec%0d", i), vecs[i].req, vecs[i].gnt, vecs[i].rv,
           vecs[i].err, vecs[i].exp_m);
    end

    step("single",     2'b01, 1'b1, 1'b0, 1'b0, 0);
    step("single_rsp", 2'b00, 1'b0, 1'b1, 1'b0, -1);

`ifdef DBUS_ARB_LOCK_EN
    m0_lock = 1'b1;
    step("lock1", 2'b11, 1'b1, 1'b0, 1'b0, 0);
    step("lock2", 2'b11, 1'b1, 1'b1, 1'b0, 0);
    step("lock3", 2'b11, 1'b1, 1'b1, 1'b0, 0);
    m0_lock = 1'b0;
    step("unlock", 2'b11, 1'b1, 1'b1, 1'b0, 1);
    step("drain",  2'b00, 1'b0, 1'b1, 1'b0, -1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

`default_nettype wire
